// File: rtl/axi_lite_regbank.sv
// axi_lite_regbank: AXI4-Lite slave with R/W control and RO status registers.
// Byte-strobe writes, independent AW/W capture, DECERR/SLVERR, write pulses.
module axi_lite_regbank #(
    parameter int                DATA_W    = 32,
    parameter int                NUM_REGS  = 8,
    parameter int                NUM_RO    = 2,
    parameter int                ADDR_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [ADDR_W-1:0]          awaddr,
    input  logic [2:0]                 awprot,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [DATA_W/8-1:0]        wstrb,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [1:0]                 bresp,
    output logic                       bvalid,
    input  logic                       bready,
    input  logic [ADDR_W-1:0]          araddr,
    input  logic [2:0]                 arprot,
    input  logic                       arvalid,
    output logic                       arready,
    output logic [DATA_W-1:0]          rdata,
    output logic [1:0]                 rresp,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [NUM_REGS*DATA_W-1:0] reg_out,
    input  logic [(NUM_RO > 0 ? NUM_RO : 1)*DATA_W-1:0] ro_in,
    output logic [NUM_REGS-1:0]        wr_pulse
);

    localparam int STRB_W = DATA_W / 8;
    localparam int B      = $clog2(STRB_W);
    localparam int I      = $clog2(NUM_REGS);
    localparam int HI     = B + I;
    localparam int NUM_RW = NUM_REGS - NUM_RO;
    localparam int ROW    = (NUM_RO > 0 ? NUM_RO : 1) * DATA_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic [DATA_W-1:0]   r_regs [NUM_RW];
    logic [ROW-1:0]      r_ro;

    logic                r_aw_held;
    logic [I-1:0]        r_aw_idx;
    logic                r_aw_dec;
    logic                r_w_held;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;

    logic                r_bvalid;
    logic [1:0]          r_bresp;
    logic [NUM_REGS-1:0] r_wr_pulse;

    logic                r_rvalid;
    logic [1:0]          r_rresp;
    logic [DATA_W-1:0]   r_rdata;

    logic [I-1:0]        w_aw_idx;
    logic                w_aw_dec;
    logic [I-1:0]        w_ar_idx;
    logic                w_ar_dec;
    logic                w_aw_fire;
    logic                w_w_fire;
    logic                w_ar_fire;
    logic                w_commit;
    logic                w_wr_ro;
    logic                w_wr_ok;
    logic [DATA_W-1:0]   w_rd_val;
    logic                w_unused;

    assign w_aw_idx  = awaddr[B +: I];
    assign w_aw_dec  = (awaddr >> HI) != '0;
    assign w_ar_idx  = araddr[B +: I];
    assign w_ar_dec  = (araddr >> HI) != '0;

    assign awready   = ~r_aw_held & ~r_bvalid;
    assign wready    = ~r_w_held & ~r_bvalid;
    assign arready   = ~r_rvalid;

    assign w_aw_fire = awvalid & awready;
    assign w_w_fire  = wvalid & wready;
    assign w_ar_fire = arvalid & arready;

    assign w_commit  = r_aw_held & r_w_held;
    assign w_wr_ro   = {1'b0, r_aw_idx} >= (I + 1)'(NUM_RW);
    assign w_wr_ok   = w_commit & ~r_aw_dec & ~w_wr_ro;

    assign bvalid    = r_bvalid;
    assign bresp     = r_bresp;
    assign wr_pulse  = r_wr_pulse;
    assign rvalid    = r_rvalid;
    assign rresp     = r_rresp;
    assign rdata     = r_rdata;

    assign w_unused  = ^{awprot, arprot, awaddr[B-1:0], araddr[B-1:0]};

    // Capture the write address and write data into their own holders
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_aw_held <= 1'b0;
            r_aw_idx  <= '0;
            r_aw_dec  <= 1'b0;
            r_w_held  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else if (w_commit) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
        end else begin
            if (w_aw_fire) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= w_aw_idx;
                r_aw_dec  <= w_aw_dec;
            end
            if (w_w_fire) begin
                r_w_held <= 1'b1;
                r_wdata  <= wdata;
                r_wstrb  <= wstrb;
            end
        end
    end

    // Byte-lane update of the addressed R/W register on commit
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_RW; i++) begin
                r_regs[i] <= RESET_VAL;
            end
        end else if (w_wr_ok) begin
            for (int i = 0; i < NUM_RW; i++) begin
                if (r_aw_idx == I'(i)) begin
                    for (int k = 0; k < STRB_W; k++) begin
                        if (r_wstrb[k]) begin
                            r_regs[i][8*k +: 8] <= r_wdata[8*k +: 8];
                        end
                    end
                end
            end
        end
    end

    // Write response and one-cycle write pulse
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (w_commit) begin
                r_bvalid <= 1'b1;
                if (r_aw_dec) begin
                    r_bresp <= RESP_DECERR;
                end else if (w_wr_ro) begin
                    r_bresp <= RESP_SLVERR;
                end else begin
                    r_bresp    <= RESP_OKAY;
                    r_wr_pulse <= NUM_REGS'(1) << r_aw_idx;
                end
            end else if (r_bvalid & bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read source mux: R/W registers or live status inputs
    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (w_ar_idx == I'(i)) begin
                w_rd_val = r_regs[i];
            end
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (w_ar_idx == I'(NUM_RW + j)) begin
                w_rd_val = ro_in[j*DATA_W +: DATA_W];
            end
        end
    end

    // Read channel: load data on accept, hold until taken
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_rvalid <= 1'b0;
            r_rresp  <= RESP_OKAY;
            r_rdata  <= '0;
        end else if (w_ar_fire) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_ar_dec ? RESP_DECERR : RESP_OKAY;
            r_rdata  <= w_ar_dec ? '0 : w_rd_val;
        end else if (r_rvalid & rready) begin
            r_rvalid <= 1'b0;
        end
    end

    // Registered copy of status inputs keeps reg_out free of input paths
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_ro <= '0;
        end else begin
            r_ro <= ro_in;
        end
    end

    // Flatten registers and status copy onto reg_out
    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            reg_out[i*DATA_W +: DATA_W] = r_regs[i];
        end
        for (int j = 0; j < NUM_RO; j++) begin
            reg_out[(NUM_RW+j)*DATA_W +: DATA_W] = r_ro[j*DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// tb_axi_lite_regbank: directed bench with response scoreboards.
// Expected B/R responses are queued at issue and compared on arrival.
module tb_axi_lite_regbank;

    logic         clock;
    logic         reset_n;
    logic [31:0]  awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [31:0]  araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [255:0] reg_out;
    logic [63:0]  ro_in;
    logic [7:0]   wr_pulse;

    int vectors = 0;
    int miscompares = 0;

    logic [1:0]  b_q [$];
    logic [7:0]  p_q [$];
    logic [33:0] r_q [$];
    logic [31:0] model [6];

    axi_lite_regbank #(
        .DATA_W   (32),
        .NUM_REGS (8),
        .NUM_RO   (2),
        .ADDR_W   (32),
        .RESET_VAL(32'h0)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .awaddr  (awaddr),
        .awprot  (awprot),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arprot  (arprot),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .reg_out (reg_out),
        .ro_in   (ro_in),
        .wr_pulse(wr_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s_reg%0d", tag, i),
                64'(reg_out[i*32 +: 32]), 64'(model[i]));
        end
    endtask

    task automatic wait_b(input string tag, input bit cp, output int lat);
        logic [1:0] er;
        logic [7:0] ep;
        int n;
        n = 0;
        bready = 1'b1;
        while (!bvalid && n < 20) begin
            step();
            n++;
        end
        lat = n;
        chk({tag, "_bvalid"}, 64'(bvalid), 64'(1));
        if (bvalid) begin
            er = b_q.pop_front();
            ep = p_q.pop_front();
            chk({tag, "_bresp"}, 64'(bresp), 64'(er));
            if (cp) chk({tag, "_pulse"}, 64'(wr_pulse), 64'(ep));
        end
        step();
        bready = 1'b0;
        chk({tag, "_pulse_off"}, 64'(wr_pulse), 64'(0));
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [1:0] er,
                      input logic [7:0] ep, input string tag,
                      output int lat);
        bit af;
        bit wf;
        int n;
        b_q.push_back(er);
        p_q.push_back(ep);
        awaddr = a;
        wdata = d;
        wstrb = s;
        awvalid = 1'b1;
        wvalid = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            af = awvalid && awready;
            wf = wvalid && wready;
            step();
            if (af) awvalid = 1'b0;
            if (wf) wvalid = 1'b0;
            n++;
        end
        chk({tag, "_accept"}, 64'({awvalid, wvalid}), 64'(0));
        awvalid = 1'b0;
        wvalid = 1'b0;
        wait_b(tag, 1'b1, lat);
    endtask

    task automatic wait_r(input string tag);
        logic [33:0] e;
        int n;
        n = 0;
        rready = 1'b1;
        while (!rvalid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_rvalid"}, 64'(rvalid), 64'(1));
        if (rvalid) begin
            e = r_q.pop_front();
            chk({tag, "_rdata"}, 64'(rdata), 64'(e[31:0]));
            chk({tag, "_rresp"}, 64'(rresp), 64'(e[33:32]));
        end
        step();
        rready = 1'b0;
        chk({tag, "_rvalid_off"}, 64'(rvalid), 64'(0));
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] ed,
                      input logic [1:0] er, input string tag);
        bit f;
        int n;
        r_q.push_back({er, ed});
        araddr = a;
        arvalid = 1'b1;
        n = 0;
        while (arvalid && n < 20) begin
            f = arready;
            step();
            if (f) arvalid = 1'b0;
            n++;
        end
        chk({tag, "_ar_accept"}, 64'(arvalid), 64'(0));
        arvalid = 1'b0;
        wait_r(tag);
    endtask

    initial begin
        int lat;
        logic [31:0] held;
        reset_n = 1'b0;
        awaddr = '0;
        awprot = '0;
        awvalid = 1'b0;
        wdata = '0;
        wstrb = '0;
        wvalid = 1'b0;
        bready = 1'b0;
        araddr = '0;
        arprot = '0;
        arvalid = 1'b0;
        rready = 1'b0;
        ro_in = {32'h0000_0000, 32'h0000_A5A5};
        for (int i = 0; i < 6; i++) model[i] = 32'h0;

        step();
        step();
        chk("rst_bvalid", 64'(bvalid), 64'(0));
        chk("rst_rvalid", 64'(rvalid), 64'(0));
        chk("rst_ready", 64'({awready, wready, arready}), 64'(3'b111));
        chk("rst_resp", 64'({bresp, rresp}), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));
        chk("rst_pulse", 64'(wr_pulse), 64'(0));
        reset_n = 1'b1;
        step();
        chk_regs("rst");

        for (int i = 0; i < 6; i++) begin
            rd(32'(i * 4), 32'h0, 2'b00, $sformatf("rd_rst%0d", i));
        end
        rd(32'h18, 32'h0000_A5A5, 2'b00, "rd_ro0");
        chk("ro_mirror", 64'(reg_out[223:192]), 64'(32'h0000_A5A5));

        wr(32'h04, 32'hDEAD_BEEF, 4'b1111, 2'b00, 8'b0000_0010, "wr1", lat);
        chk("wr1_latency", 64'(lat), 64'(1));
        model[1] = 32'hDEAD_BEEF;
        chk("wr1_reg1", 64'(reg_out[63:32]), 64'(32'hDEAD_BEEF));

        wr(32'h04, 32'h1234_5678, 4'b0101, 2'b00, 8'b0000_0010, "wr2", lat);
        model[1] = 32'hDE34_BE78;
        chk_regs("wr2");
        rd(32'h04, 32'hDE34_BE78, 2'b00, "rd_wr2");

        wdata = 32'h55;
        wstrb = 4'b1111;
        wvalid = 1'b1;
        chk("wfirst_wready", 64'(wready), 64'(1));
        step();
        wvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("wfirst_gap%0d", c),
                64'({wready, awready, bvalid}), 64'(3'b010));
            step();
        end
        b_q.push_back(2'b00);
        p_q.push_back(8'b0000_0100);
        awaddr = 32'h08;
        awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        chk("wfirst_bvalid_early", 64'(bvalid), 64'(0));
        step();
        chk("wfirst_bvalid", 64'(bvalid), 64'(1));
        chk("wfirst_pulse", 64'(wr_pulse), 64'(8'b0000_0100));
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("stall%0d", c),
                64'({bvalid, bresp, awready, wready}), 64'(5'b1_00_00));
        end
        wait_b("wfirst", 1'b0, lat);
        model[2] = 32'h55;
        chk_regs("wfirst");

        wr(32'h1C, 32'hFFFF_FFFF, 4'b1111, 2'b10, 8'h00, "wr_ro", lat);
        chk("wr_ro_mirror", 64'(reg_out[255:224]), 64'(0));
        chk_regs("wr_ro");
        wr(32'h20, 32'hFFFF_FFFF, 4'b1111, 2'b11, 8'h00, "wr_dec", lat);
        rd(32'h20, 32'h0, 2'b11, "rd_dec");
        chk_regs("dec");

        wr(32'h0C, 32'hCAFE_0000, 4'b0000, 2'b00, 8'b0000_1000, "wr_nostrb", lat);
        chk_regs("nostrb");

        b_q.push_back(2'b00);
        p_q.push_back(8'b0000_0010);
        r_q.push_back({2'b00, 32'hDE34_BE78});
        awaddr = 32'h04;
        wdata = 32'h0000_0001;
        wstrb = 4'b1111;
        awvalid = 1'b1;
        wvalid = 1'b1;
        step();
        awvalid = 1'b0;
        wvalid = 1'b0;
        araddr = 32'h04;
        arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        wait_b("raw_wr", 1'b1, lat);
        wait_r("raw_rd");
        model[1] = 32'h0000_0001;
        chk_regs("raw");

        araddr = 32'h08;
        arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        chk("rst_rd_rvalid", 64'(rvalid), 64'(1));
        held = rdata;
        step();
        chk("rst_rd_hold", 64'(rdata), 64'(32'h55));
        chk("rst_rd_stable", 64'(rdata), 64'(held));
        reset_n = 1'b0;
        step();
        chk("rst2_rvalid", 64'(rvalid), 64'(0));
        chk("rst2_arready", 64'(arready), 64'(1));
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) model[i] = 32'h0;
        chk_regs("rst2");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
